// File: rtl/dma_burst_sched_pkg.sv
// dma_sched_pkg: shared FSM states, AXI response codes and boundary size for the DMA burst scheduler.
package dma_sched_pkg;
    typedef enum logic [2:0] {IDLE, CALC, ISSUE, DRAIN, DONE_ST} state_t;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int BOUNDARY_BYTES = 4096;
endpackage

// File: rtl/dma_burst_sched_if.sv
// dma_burst_sched_if: command, AXI AR/AW/B address-channel and status signals of the DMA burst scheduler.
interface dma_burst_sched_if;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [31:0] CMD_SRC;
    logic [31:0] CMD_DEST;
    logic [31:0] CMD_LEN;
    logic [31:0] M_ARADDR;
    logic [3:0]  M_ARLEN;
    logic        M_ARVALID;
    logic        M_ARREADY;
    logic [31:0] M_AWADDR;
    logic [3:0]  M_AWLEN;
    logic        M_AWVALID;
    logic        M_AWREADY;
    logic        M_BVALID;
    logic        M_BREADY;
    logic [1:0]  M_BRESP;
    logic        DONE;
    logic        ERR;
    logic [31:0] CYCLES;
    modport master (
        input  CMD_VALID, CMD_SRC, CMD_DEST, CMD_LEN, M_ARREADY, M_AWREADY, M_BVALID, M_BRESP,
        output CMD_READY, M_ARADDR, M_ARLEN, M_ARVALID, M_AWADDR, M_AWLEN, M_AWVALID, M_BREADY,
               DONE, ERR, CYCLES
    );
    modport slave (
        output CMD_VALID, CMD_SRC, CMD_DEST, CMD_LEN, M_ARREADY, M_AWREADY, M_BVALID, M_BRESP,
        input  CMD_READY, M_ARADDR, M_ARLEN, M_ARVALID, M_AWADDR, M_AWLEN, M_AWVALID, M_BREADY,
               DONE, ERR, CYCLES
    );
endinterface

// File: rtl/dma_burst_sched_len.sv
// dma_burst_len: burst beats = min(remaining, beats to next 4 KB page of src and dest, MAX_BURST).
module dma_burst_len
    import dma_sched_pkg::*;
#(
    parameter int BEAT_BYTES = 8,
    parameter int MAX_BURST  = 16,
    parameter int IW         = $clog2(BOUNDARY_BYTES / BEAT_BYTES),
    parameter int BW         = $clog2(MAX_BURST + 1)
) (
    input  logic [IW-1:0] src_idx,
    input  logic [IW-1:0] dst_idx,
    input  logic [31:0]   rem,
    output logic [BW-1:0] burst
);
    localparam int PAGE = BOUNDARY_BYTES / BEAT_BYTES;
    logic [31:0] ds, dd, m;
    // Indices are beat positions inside the page, so each distance is always >= 1.
    always_comb begin
        ds = 32'(PAGE) - 32'(src_idx);
        dd = 32'(PAGE) - 32'(dst_idx);
        m = ds < dd ? ds : dd;
        m = rem < m ? rem : m;
        burst = BW'(m < 32'(MAX_BURST) ? m : 32'(MAX_BURST));
    end
endmodule

// File: rtl/dma_burst_sched.sv
// dma_burst_sched: splits one DMA command into paired 4 KB-safe AXI3 AR/AW bursts and tracks B responses.
// Defining DMA_BURST_SCHED_PERF_EN adds the per-command cycle counter reported on CYCLES.
module dma_burst_sched
    import dma_sched_pkg::*;
#(
    parameter int BEAT_BYTES = 8,
    parameter int MAX_BURST  = 16,
    parameter int MAX_OUT    = 4,
    parameter int OUT_W      = 3
) (
    input logic ACLK,
    input logic ARESETN,
    dma_burst_sched_if.master bus
);
    localparam int LB = $clog2(BEAT_BYTES);
    localparam int PB = $clog2(BOUNDARY_BYTES);
    localparam int BW = $clog2(MAX_BURST + 1);

    state_t           state;
    logic [31:0]      src_q, dst_q, rem_q, step;
    logic [BW-1:0]    burst_c, burst_q;
    logic [OUT_W-1:0] outst, outst_nxt;
    logic             ar_done, aw_done, ar_hs, aw_hs, b_hs, aw_ok, pair_done;

    dma_burst_len #(.BEAT_BYTES(BEAT_BYTES), .MAX_BURST(MAX_BURST)) u_len (
        .src_idx(src_q[PB-1:LB]),
        .dst_idx(dst_q[PB-1:LB]),
        .rem    (rem_q),
        .burst  (burst_c)
    );

    always_comb begin
        ar_hs = bus.M_ARVALID && bus.M_ARREADY;
        aw_hs = bus.M_AWVALID && bus.M_AWREADY;
        b_hs = bus.M_BVALID && bus.M_BREADY;
        outst_nxt = outst + OUT_W'(aw_hs) - OUT_W'(b_hs);
        aw_ok = outst_nxt < OUT_W'(MAX_OUT);
        pair_done = (ar_done || ar_hs) && (aw_done || aw_hs);
        step = 32'(burst_q) << LB;
    end

    assign bus.CMD_READY = state == IDLE;
    assign bus.M_BREADY = outst != '0;

    always_ff @(posedge ACLK) outst <= !ARESETN ? '0 : outst_nxt;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state <= IDLE;
            src_q <= '0;
            dst_q <= '0;
            rem_q <= '0;
            burst_q <= '0;
            ar_done <= 1'b0;
            aw_done <= 1'b0;
            bus.M_ARADDR <= '0;
            bus.M_AWADDR <= '0;
            bus.M_ARLEN <= '0;
            bus.M_AWLEN <= '0;
            bus.M_ARVALID <= 1'b0;
            bus.M_AWVALID <= 1'b0;
            bus.DONE <= 1'b0;
            bus.ERR <= 1'b0;
        end else begin
            bus.DONE <= 1'b0;
            if (b_hs && bus.M_BRESP != RESP_OKAY) bus.ERR <= 1'b1;
            case (state)
                IDLE: if (bus.CMD_VALID) begin
                    src_q <= bus.CMD_SRC;
                    dst_q <= bus.CMD_DEST;
                    rem_q <= bus.CMD_LEN >> LB;
                    bus.ERR <= 1'b0;
                    state <= (bus.CMD_LEN >> LB) == '0 ? DONE_ST : CALC;
                end
                CALC: begin
                    bus.M_ARADDR <= src_q;
                    bus.M_AWADDR <= dst_q;
                    bus.M_ARLEN <= 4'(burst_c - BW'(1));
                    bus.M_AWLEN <= 4'(burst_c - BW'(1));
                    bus.M_ARVALID <= 1'b1;
                    bus.M_AWVALID <= aw_ok;
                    burst_q <= burst_c;
                    ar_done <= 1'b0;
                    aw_done <= 1'b0;
                    state <= ISSUE;
                end
                ISSUE: begin
                    if (ar_hs) begin
                        bus.M_ARVALID <= 1'b0;
                        ar_done <= 1'b1;
                    end
                    // AW waits for a free outstanding slot; once raised it stays up until accepted.
                    if (aw_hs) begin
                        bus.M_AWVALID <= 1'b0;
                        aw_done <= 1'b1;
                    end else if (!aw_done && !bus.M_AWVALID) bus.M_AWVALID <= aw_ok;
                    if (pair_done) begin
                        src_q <= src_q + step;
                        dst_q <= dst_q + step;
                        rem_q <= rem_q - 32'(burst_q);
                        state <= rem_q == 32'(burst_q) ? DRAIN : CALC;
                    end
                end
                DRAIN: if (outst == '0) state <= DONE_ST;
                DONE_ST: begin
                    bus.DONE <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMA_BURST_SCHED_PERF_EN
    logic [31:0] cnt;
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            cnt <= '0;
            bus.CYCLES <= '0;
        end else begin
            cnt <= state == IDLE ? (bus.CMD_VALID ? '0 : cnt) : cnt + 32'd1;
            if (state == DONE_ST) bus.CYCLES <= cnt;
        end
    end
`else
    assign bus.CYCLES = '0;
`endif
endmodule

// File: tb/tb_dma_burst_sched.sv
// tb_dma_burst_sched: directed scenarios for dma_burst_sched with a small AXI slave that answers B per AW.
module tb_dma_burst_sched;
    import dma_sched_pkg::*;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    always #5 ACLK = ~ACLK;

    dma_burst_sched_if bus();
    dma_burst_sched dut (.ACLK(ACLK), .ARESETN(ARESETN), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    logic [31:0] ar_a[$];
    logic [3:0]  ar_l[$];
    logic [31:0] aw_a[$];
    logic [3:0]  aw_l[$];
    int          aw_c[$];
    int          b_c[$];
    int          done_n = 0;
    int          done_b = 0;
    int          pend = 0;
    logic        b_en = 1'b1;
    logic        bad_next = 1'b0;
    logic        stray = 1'b0;

    // Handshakes are observed at negedge; slave inputs change just after posedge.
    initial begin
        logic arh, awh, bh;
        forever begin
            @(negedge ACLK);
            arh = bus.M_ARVALID && bus.M_ARREADY;
            awh = bus.M_AWVALID && bus.M_AWREADY;
            bh = bus.M_BVALID && bus.M_BREADY;
            if (arh) begin
                ar_a.push_back(bus.M_ARADDR);
                ar_l.push_back(bus.M_ARLEN);
            end
            if (awh) begin
                aw_a.push_back(bus.M_AWADDR);
                aw_l.push_back(bus.M_AWLEN);
                aw_c.push_back(cyc);
            end
            if (bh) begin
                b_c.push_back(cyc);
                if (bus.M_BRESP != RESP_OKAY) bad_next = 1'b0;
            end
            if (bus.DONE) begin
                done_n++;
                done_b = b_c.size();
            end
            @(posedge ACLK);
            #2;
            pend = !ARESETN ? 0 : pend + int'(awh) - int'(bh);
            bus.M_BVALID = stray || (b_en && pend > 0);
            bus.M_BRESP = bad_next ? RESP_SLVERR : RESP_OKAY;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_logs();
        ar_a.delete(); ar_l.delete(); aw_a.delete(); aw_l.delete(); aw_c.delete(); b_c.delete();
        done_n = 0;
        done_b = 0;
    endtask

    task automatic send_cmd(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l, output int c);
        @(posedge ACLK);
        #1;
        bus.CMD_VALID = 1'b1;
        bus.CMD_SRC = s;
        bus.CMD_DEST = d;
        bus.CMD_LEN = l;
        c = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge ACLK);
            if (bus.CMD_READY) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: CMD_READY never seen, required 1");
        end
        @(posedge ACLK);
        #1;
        bus.CMD_VALID = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int d);
        d = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge ACLK);
            if (bus.DONE) begin
                d = cyc;
                break;
            end
        end
        if (d < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: DONE not seen within %0d cycles", lim);
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({bus.CMD_READY, bus.M_ARVALID, bus.M_AWVALID, bus.M_BREADY, bus.DONE, bus.ERR} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/arv/awv/brdy/done/err=%b required 100000",
                {bus.CMD_READY, bus.M_ARVALID, bus.M_AWVALID, bus.M_BREADY, bus.DONE, bus.ERR});
        end
        checks++;
        if ({bus.M_ARADDR, bus.M_AWADDR, bus.M_ARLEN, bus.M_AWLEN, bus.CYCLES} !== 104'd0) begin
            errors++;
            $display("FAIL reset_regs: araddr=%h awaddr=%h arlen=%0d awlen=%0d cycles=%0d required all 0",
                bus.M_ARADDR, bus.M_AWADDR, bus.M_ARLEN, bus.M_AWLEN, bus.CYCLES);
        end
    endtask

    task automatic test_split();
        int c, d;
        logic [31:0] exp_cyc;
        clear_logs();
        send_cmd(32'h1000_0000, 32'h2000_0000, 32'd256, c);
        wait_done(200, d);
`ifdef DMA_BURST_SCHED_PERF_EN
        exp_cyc = 32'(d - c - 2);
`else
        exp_cyc = 32'd0;
`endif
        repeat (4) @(negedge ACLK);
        checks++;
        if (ar_a.size() !== 2 || aw_a.size() !== 2) begin
            errors++;
            $display("FAIL split_count: ar=%0d aw=%0d required 2 and 2", ar_a.size(), aw_a.size());
        end
        checks++;
        if (ar_a[0] !== 32'h1000_0000 || ar_a[1] !== 32'h1000_0080) begin
            errors++;
            $display("FAIL split_araddr: %h %h required 10000000 10000080", ar_a[0], ar_a[1]);
        end
        checks++;
        if (aw_a[0] !== 32'h2000_0000 || aw_a[1] !== 32'h2000_0080) begin
            errors++;
            $display("FAIL split_awaddr: %h %h required 20000000 20000080", aw_a[0], aw_a[1]);
        end
        checks++;
        if ({ar_l[0], ar_l[1], aw_l[0], aw_l[1]} !== 16'hFFFF) begin
            errors++;
            $display("FAIL split_len: ar %0d %0d aw %0d %0d required all 15", ar_l[0], ar_l[1], aw_l[0], aw_l[1]);
        end
        checks++;
        if (done_n !== 1 || done_b !== 2) begin
            errors++;
            $display("FAIL split_done: pulses=%0d b_before=%0d required 1 and 2", done_n, done_b);
        end
        checks++;
        if (bus.CYCLES !== exp_cyc) begin
            errors++;
            $display("FAIL split_cycles: got %0d required %0d", bus.CYCLES, exp_cyc);
        end
    endtask

    task automatic test_boundary();
        int c, d;
        clear_logs();
        send_cmd(32'h0000_0FC0, 32'h3000_0000, 32'd128, c);
        wait_done(200, d);
        repeat (4) @(negedge ACLK);
        checks++;
        if (ar_a.size() !== 2 || ar_a[0] !== 32'h0000_0FC0 || ar_a[1] !== 32'h0000_1000) begin
            errors++;
            $display("FAIL bnd_araddr: n=%0d %h %h required 2 00000fc0 00001000", ar_a.size(), ar_a[0], ar_a[1]);
        end
        checks++;
        if (aw_a.size() !== 2 || aw_a[0] !== 32'h3000_0000 || aw_a[1] !== 32'h3000_0040) begin
            errors++;
            $display("FAIL bnd_awaddr: n=%0d %h %h required 2 30000000 30000040", aw_a.size(), aw_a[0], aw_a[1]);
        end
        checks++;
        if ({ar_l[0], ar_l[1], aw_l[0], aw_l[1]} !== 16'h7777) begin
            errors++;
            $display("FAIL bnd_len: ar %0d %0d aw %0d %0d required all 7", ar_l[0], ar_l[1], aw_l[0], aw_l[1]);
        end
    endtask

    task automatic test_short();
        int c, d;
        clear_logs();
        send_cmd(32'h0000_1000, 32'h0000_2000, 32'd5, c);
        wait_done(20, d);
        repeat (3) @(negedge ACLK);
        checks++;
        if (d - c !== 2) begin
            errors++;
            $display("FAIL short_latency: DONE %0d cycles after handshake, required 2", d - c);
        end
        checks++;
        if (ar_a.size() !== 0 || aw_a.size() !== 0) begin
            errors++;
            $display("FAIL short_bursts: ar=%0d aw=%0d required 0 and 0", ar_a.size(), aw_a.size());
        end
    endtask

    task automatic test_outstanding();
        int c, d;
        clear_logs();
        b_en = 1'b0;
        send_cmd(32'h5000_0000, 32'h4000_0000, 32'd1024, c);
        repeat (40) @(negedge ACLK);
        checks++;
        if (aw_a.size() !== 4 || ar_a.size() !== 5 || bus.M_AWVALID !== 1'b0) begin
            errors++;
            $display("FAIL out_limit: aw=%0d ar=%0d awvalid=%b required 4 5 0", aw_a.size(), ar_a.size(), bus.M_AWVALID);
        end
        @(posedge ACLK);
        #1;
        b_en = 1'b1;
        wait_done(300, d);
        repeat (4) @(negedge ACLK);
        checks++;
        if (aw_c[4] - b_c[0] !== 1) begin
            errors++;
            $display("FAIL out_resume: fifth AW %0d cycles after first B, required 1", aw_c[4] - b_c[0]);
        end
        checks++;
        if (aw_a.size() !== 8 || aw_a[4] !== 32'h4000_0200 || aw_a[7] !== 32'h4000_0380) begin
            errors++;
            $display("FAIL out_total: n=%0d aw4=%h aw7=%h required 8 40000200 40000380", aw_a.size(), aw_a[4], aw_a[7]);
        end
    endtask

    task automatic test_error();
        int c, d;
        clear_logs();
        bad_next = 1'b1;
        send_cmd(32'h0000_0100, 32'h0000_0200, 32'd64, c);
        wait_done(100, d);
        checks++;
        if (bus.ERR !== 1'b1) begin
            errors++;
            $display("FAIL err_set: ERR=%b at DONE, required 1", bus.ERR);
        end
        repeat (5) @(negedge ACLK);
        checks++;
        if (bus.ERR !== 1'b1 || ar_l[0] !== 4'd7) begin
            errors++;
            $display("FAIL err_hold: ERR=%b arlen=%0d required 1 and 7", bus.ERR, ar_l[0]);
        end
        send_cmd(32'h0000_0100, 32'h0000_0200, 32'd5, c);
        wait_done(20, d);
        checks++;
        if (bus.ERR !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: ERR=%b after next command, required 0", bus.ERR);
        end
    endtask

    task automatic test_reset_mid();
        int c, d;
        logic [31:0] exp_cyc;
        clear_logs();
        bus.M_ARREADY = 1'b0;
        bus.M_AWREADY = 1'b0;
        send_cmd(32'h6000_0000, 32'h7000_0000, 32'd256, c);
        repeat (3) @(negedge ACLK);
        checks++;
        if ({bus.M_ARVALID, bus.M_AWVALID, bus.CMD_READY} !== 3'b110) begin
            errors++;
            $display("FAIL mid_issue: arv/awv/rdy=%b required 110", {bus.M_ARVALID, bus.M_AWVALID, bus.CMD_READY});
        end
        @(posedge ACLK);
        #1;
        ARESETN = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        checks++;
        if ({bus.M_ARVALID, bus.M_AWVALID, bus.CMD_READY, bus.M_BREADY} !== 4'b0010) begin
            errors++;
            $display("FAIL mid_reset: arv/awv/rdy/brdy=%b required 0010",
                {bus.M_ARVALID, bus.M_AWVALID, bus.CMD_READY, bus.M_BREADY});
        end
        @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        stray = 1'b1;
        bus.M_ARREADY = 1'b1;
        bus.M_AWREADY = 1'b1;
        repeat (4) @(negedge ACLK);
        checks++;
        if (bus.M_BREADY !== 1'b0 || b_c.size() !== 0) begin
            errors++;
            $display("FAIL stray_b: bready=%b b_accepted=%0d required 0 and 0", bus.M_BREADY, b_c.size());
        end
        @(posedge ACLK);
        #1;
        stray = 1'b0;
        send_cmd(32'h1000_0000, 32'h2000_0000, 32'd256, c);
        wait_done(200, d);
`ifdef DMA_BURST_SCHED_PERF_EN
        exp_cyc = 32'(d - c - 2);
`else
        exp_cyc = 32'd0;
`endif
        repeat (3) @(negedge ACLK);
        checks++;
        if (bus.CYCLES !== exp_cyc || aw_a.size() !== 2) begin
            errors++;
            $display("FAIL post_reset: cycles=%0d aw=%0d required %0d and 2", bus.CYCLES, aw_a.size(), exp_cyc);
        end
    endtask

    initial begin
        bus.CMD_VALID = 1'b0;
        bus.CMD_SRC = '0;
        bus.CMD_DEST = '0;
        bus.CMD_LEN = '0;
        bus.M_ARREADY = 1'b1;
        bus.M_AWREADY = 1'b1;
        bus.M_BVALID = 1'b0;
        bus.M_BRESP = RESP_OKAY;
        test_reset();
        test_split();
        test_boundary();
        test_short();
        test_outstanding();
        test_error();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
